excep_requester: RTL
====================

// Module: excep_requester
// PURPOSE
//  Initiator side of the exception request/acknowledge handshake. Collects per-source
//  exception events from the pipeline, latches them as sticky pending bits and
//  prioritises them. Drives one excepCode at a time to the controller and holds it
//  stable until ack, then releases. Sits between pipeline fault detection and the
//  controller's ack register; also captures the faulting PC for SRR0.
// PARAMETERS
//  TIMEOUT  16  cycles in REQ without ack before the timeout flag sets (>=2)
//  PC_W     32  width of the PC capture path
//  ExcepCode_WIDTH and all ExcepCode_* values come from Interrupt_def.v, not parameters.
// PORTS
//  clk         in   1     rising-edge clock
//  rst_n       in   1     asynchronous reset, active-low
//  evFetch     in   1     instruction fetch fault event (1-cycle pulse or level)
//  evUndef     in   1     undefined-instruction event
//  evPriv      in   1     privileged-instruction event
//  evTrap      in   1     trap event
//  evSpr       in   1     illegal move-to/from-SPR event
//  evSc        in   1     system-call event
//  evLoad      in   1     load access fault event
//  evStore     in   1     store access fault event
//  evExt       in   1     external interrupt request (level)
//  msrEE       in   1     external interrupt enable; masks evExt only
//  pcIn        in   PC_W  PC of the instruction raising the event this cycle
//  ack         in   1     acknowledge from controller (registered on its side)
//  excepCode   out  W     current request code; ExcepCode_NONE when idle
//  srr0        out  PC_W  PC latched when the current request was issued
//  taken       out  1     1-cycle pulse on the cycle ack is first seen in REQ
//  busy        out  1     1 whenever state != IDLE
//  timeout     out  1     sticky: ack not seen within TIMEOUT cycles of REQ entry
//  spurious    out  1     sticky: ack seen high while IDLE
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, pending=0, excepCode=NONE, srr0=0, taken=0,
//   busy=0, timeout=0, spurious=0, counter=0. Applies mid-handshake; it drops excepCode at once.
//  Pending: each cycle pending |= events; evExt contributes only when msrEE=1.
//   An event on an already-pending source is merged and is not counted twice.
//   Events are never lost in any state.
//  Priority, high->low: FETCH, UNDEF, PRIV, TRAP, SPR, SC, LOAD, STORE, EXT.
//  FSM, excepCode is registered:
//   IDLE:    if pending!=0 -> REQ. Latch the top-priority code into excepCode. Latch srr0
//            from pcIn if that source fires this cycle, else keep the value captured
//            when the bit was set. One srr0 slot per pending bit: 9 x PC_W.
//   REQ:     excepCode held stable, including when a higher-priority event arrives.
//            Counter increments and saturates. On reaching TIMEOUT-1, timeout<=1;
//            remain in REQ. On ack=1: taken=1, clear the served pending bit (unless
//            the same source re-fires this cycle), excepCode<=NONE, counter<=0 -> REL.
//   REL:     wait for ack=0 -> IDLE. Four-phase handshake; no new request while ack=1.
//  Latency: a pulse in IDLE gives excepCode valid on the next edge. Minimum
//   round-trip IDLE->REQ->REL->IDLE is 4 cycles with the controller's 1-cycle ack.
//  ack=1 while IDLE sets spurious and is otherwise ignored.
//  Back-to-back: if pending is still non-zero on return to IDLE, re-enter REQ the next cycle.
// STRUCTURE
//  Interrupt_def.v (shared): ExcepCode_WIDTH=4; NONE=4'h0, FETCH=1, UNDEF=2, PRIV=3,
//   TRAP=4, LOAD=5, STORE=6, SPR=7, SC=8, EXT=9; state encodings IDLE/REQ/REL.
//  Sub-module excep_prio_enc: combinational 9-bit pending -> {code, one-hot select}.
//   Reused by any later vectored-interrupt logic.
// TESTING
//  1 evUndef pulse at t0 -> code=2 at t1, srr0=pcIn@t0; ack at t2 -> taken@t2,
//    code=NONE@t3, busy=0 once ack drops.
//  2 evFetch+evStore+evExt(msrEE=1) same cycle -> codes 1, 6, 9 issued in order,
//    each after a full 4-phase handshake.
//  3 evTrap while REQ serving code 6 -> code stays 6 until ack; code 4 issued next.
//  4 evExt with msrEE=0 -> stays IDLE; raise msrEE -> code 9 next cycle.
//  5 hold ack=0 in REQ, TIMEOUT=16 -> timeout=1 after 16 cycles, code unchanged;
//    later ack still completes.
//  6 rst_n low mid-REQ -> all outputs reset asynchronously; ack in IDLE -> spurious=1.

Source files
------------

// File: rtl/excep_requester_pkg.sv
// Shared exception codes, source ordering and request FSM states for the
// exception requester slice.
package excep_requester_pkg;

  localparam int unsigned ExcepCode_WIDTH = 4;
  typedef logic [ExcepCode_WIDTH-1:0] excepCode_t;

  localparam excepCode_t ExcepCode_NONE  = 4'h0;
  localparam excepCode_t ExcepCode_FETCH = 4'h1;
  localparam excepCode_t ExcepCode_UNDEF = 4'h2;
  localparam excepCode_t ExcepCode_PRIV  = 4'h3;
  localparam excepCode_t ExcepCode_TRAP  = 4'h4;
  localparam excepCode_t ExcepCode_LOAD  = 4'h5;
  localparam excepCode_t ExcepCode_STORE = 4'h6;
  localparam excepCode_t ExcepCode_SPR   = 4'h7;
  localparam excepCode_t ExcepCode_SC    = 4'h8;
  localparam excepCode_t ExcepCode_EXT   = 4'h9;

  localparam int unsigned NUM_SRC = 9;

  // Pending-vector bit index equals priority rank (0 = highest).
  localparam int unsigned SRC_FETCH = 0;
  localparam int unsigned SRC_UNDEF = 1;
  localparam int unsigned SRC_PRIV  = 2;
  localparam int unsigned SRC_TRAP  = 3;
  localparam int unsigned SRC_SPR   = 4;
  localparam int unsigned SRC_SC    = 5;
  localparam int unsigned SRC_LOAD  = 6;
  localparam int unsigned SRC_STORE = 7;
  localparam int unsigned SRC_EXT   = 8;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    REL
  } reqState_t;

  function automatic excepCode_t srcCode(input int unsigned idx);
    case (idx)
      SRC_FETCH: srcCode = ExcepCode_FETCH;
      SRC_UNDEF: srcCode = ExcepCode_UNDEF;
      SRC_PRIV:  srcCode = ExcepCode_PRIV;
      SRC_TRAP:  srcCode = ExcepCode_TRAP;
      SRC_SPR:   srcCode = ExcepCode_SPR;
      SRC_SC:    srcCode = ExcepCode_SC;
      SRC_LOAD:  srcCode = ExcepCode_LOAD;
      SRC_STORE: srcCode = ExcepCode_STORE;
      SRC_EXT:   srcCode = ExcepCode_EXT;
      default:   srcCode = ExcepCode_NONE;
    endcase
  endfunction

endpackage

// File: rtl/excep_requester_prio_enc.sv
// Fixed-priority encoder: pending sources -> winning exception code plus a
// one-hot select of the winning source.
module excep_prio_enc
  import excep_requester_pkg::*;
(
  input  logic [NUM_SRC-1:0]         pending,
  output logic [ExcepCode_WIDTH-1:0] code,
  output logic [NUM_SRC-1:0]         sel
);

  // Scan from lowest priority upwards so the highest-priority hit is written last.
  always_comb begin
    code = ExcepCode_NONE;
    sel  = '0;
    for (int unsigned i = NUM_SRC; i > 0; i--) begin
      if (pending[i-1]) begin
        code     = srcCode(i-1);
        sel      = '0;
        sel[i-1] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/excep_requester.sv
// Exception request initiator: sticky pending sources, priority selection and a
// four-phase req/ack handshake towards the exception controller.
module excep_requester
  import excep_requester_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned PC_W    = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       evFetch,
  input  logic                       evUndef,
  input  logic                       evPriv,
  input  logic                       evTrap,
  input  logic                       evSpr,
  input  logic                       evSc,
  input  logic                       evLoad,
  input  logic                       evStore,
  input  logic                       evExt,
  input  logic                       msrEE,
  input  logic [PC_W-1:0]            pcIn,
  input  logic                       ack,
  output logic [ExcepCode_WIDTH-1:0] excepCode,
  output logic [PC_W-1:0]            srr0,
  output logic                       taken,
  output logic                       busy,
  output logic                       timeout,
  output logic                       spurious
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT);

  reqState_t           state;
  logic [NUM_SRC-1:0]  pending;
  logic [NUM_SRC-1:0]  events;
  logic [NUM_SRC-1:0]  merged;
  logic [NUM_SRC-1:0]  servedSel;
  logic [NUM_SRC-1:0]  clearSel;
  logic [NUM_SRC-1:0]  winSel;
  excepCode_t          winCode;
  logic [PC_W-1:0]     pcSlot [NUM_SRC];
  logic [PC_W-1:0]     slotPc;
  logic [PC_W-1:0]     issuePc;
  logic [CNT_W-1:0]    counter;

  assign events = {evExt & msrEE, evStore, evLoad, evSc, evSpr,
                   evTrap, evPriv, evUndef, evFetch};
  assign merged   = pending | events;
  assign clearSel = (state == REQ && ack) ? servedSel : '0;

  excep_prio_enc uPrioEnc (
    .pending (merged),
    .code    (winCode),
    .sel     (winSel)
  );

  assign taken = (state == REQ) && ack;
  assign busy  = (state != IDLE);

  // A slot is refreshed when its bit is newly set, or re-fires as it is being served.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_SRC; i++) pcSlot[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        if (events[i] && (!pending[i] || clearSel[i])) pcSlot[i] <= pcIn;
      end
    end
  end

  always_comb begin
    slotPc = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (winSel[i]) slotPc = pcSlot[i];
    end
  end

  assign issuePc = |(events & winSel) ? pcIn : slotPc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pending   <= '0;
      servedSel <= '0;
      excepCode <= ExcepCode_NONE;
      srr0      <= '0;
      counter   <= '0;
      timeout   <= 1'b0;
      spurious  <= 1'b0;
    end else begin
      pending <= merged & ~(clearSel & ~events);
      case (state)
        IDLE: begin
          if (ack) spurious <= 1'b1;
          if (|merged) begin
            state     <= REQ;
            excepCode <= winCode;
            servedSel <= winSel;
            srr0      <= issuePc;
            counter   <= '0;
          end
        end
        REQ: begin
          if (ack) begin
            state     <= REL;
            excepCode <= ExcepCode_NONE;
            counter   <= '0;
          end else if (counter == CNT_W'(TIMEOUT - 1)) begin
            timeout <= 1'b1;
          end else begin
            counter <= counter + 1'b1;
          end
        end
        REL: begin
          if (!ack) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
